pmem_arbiter: RTL

PMEM_ARBITER -- requirements
Module: pmem_arbiter

---
 rtl/pmem_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/pmem_arbiter.sv
// Physical-memory arbiter: shares one pmem port among icache fills, dcache fills
// and write-back drains, with a starvation limit that eventually favours write-back.
module pmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         icache_pmem_read,
    input  logic [15:0]  icache_pmem_address,
    output logic         icache_pmem_resp,
    output logic [127:0] icache_pmem_rdata,

    input  logic         dcache_pmem_read,
    input  logic [15:0]  dcache_pmem_address,
    output logic         dcache_pmem_resp,
    output logic [127:0] dcache_pmem_rdata,

    input  logic         wb_pmem_write,
    input  logic [15:0]  wb_pmem_address,
    input  logic [127:0] wb_pmem_wdata,
    input  logic         wb_full,
    output logic         wb_pmem_resp,

    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [127:0] pmem_rdata
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, GNT_WB} state_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t       state;
    state_t       next_state;
    logic [2:0]   starve_cnt;
    logic [15:0]  addr_q;
    logic [127:0] wdata_q;
    logic         wb_urgent;

    assign wb_urgent = wb_pmem_write && (wb_full || starve_cnt == LIMIT);

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (wb_urgent)             next_state = GNT_WB;
                else if (dcache_pmem_read) next_state = GNT_D;
                else if (icache_pmem_read) next_state = GNT_I;
                else if (wb_pmem_write)    next_state = GNT_WB;
            end
            GNT_I, GNT_D, GNT_WB: begin
                if (pmem_resp) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Address/data are captured only on the grant edge so a requester may drop
    // or change its inputs while its transaction is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE) begin
                unique case (next_state)
                    GNT_I, GNT_D: begin
                        addr_q <= (next_state == GNT_I) ? icache_pmem_address
                                                        : dcache_pmem_address;
                        if (wb_pmem_write && starve_cnt < LIMIT)
                            starve_cnt <= starve_cnt + 3'd1;
                    end
                    GNT_WB: begin
                        addr_q     <= wb_pmem_address;
                        wdata_q    <= wb_pmem_wdata;
                        starve_cnt <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pmem_read         = (state == GNT_I) || (state == GNT_D);
    assign pmem_write        = (state == GNT_WB);
    assign pmem_address      = addr_q;
    assign pmem_wdata        = wdata_q;
    assign icache_pmem_resp  = (state == GNT_I)  && pmem_resp;
    assign dcache_pmem_resp  = (state == GNT_D)  && pmem_resp;
    assign wb_pmem_resp      = (state == GNT_WB) && pmem_resp;
    assign icache_pmem_rdata = pmem_rdata;
    assign dcache_pmem_rdata = pmem_rdata;

endmodule
